// File: rtl/ls299.sv
// 74LS299 8-bit universal shift/storage register, modelled in the system clock domain.
// The chip clock pin is sampled on clk, and a rising edge triggers the selected mode action.
module ls299 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cp,
  input  logic       mr_n,
  input  logic       s0,
  input  logic       s1,
  input  logic       oe1_n,
  input  logic       oe2_n,
  input  logic       ds0,
  input  logic       ds7,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       q0s,
  output logic       q7s
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [7:0] r_q;
  logic       r_cp_prev;
  logic       w_cp_rise;
  mode_e      w_mode;

  assign w_mode    = mode_e'({s1, s0});
  assign w_cp_rise = cp & ~r_cp_prev;

  // cp_prev resets high so that a cp held high across reset release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q       <= '0;
      r_cp_prev <= 1'b1;
    end else begin
      r_cp_prev <= cp;
      if (!mr_n) begin
        r_q <= '0;
      end else if (w_cp_rise) begin
        case (w_mode)
          MODE_SHR:  r_q <= {r_q[6:0], ds0};
          MODE_SHL:  r_q <= {ds7, r_q[7:1]};
          MODE_LOAD: r_q <= io_in;
          default:   r_q <= r_q;
        endcase
      end
    end
  end

  assign io_out = r_q;
  assign q0s    = r_q[0];
  assign q7s    = r_q[7];
  // Mode 11 always releases the pins so they can be loaded.
  assign io_oe  = ~oe1_n & ~oe2_n & ~(s0 & s1);

endmodule

// File: tb/tb_ls299.sv
// Self-checking bench for ls299: expected register values are queued when a cp action
// is driven and popped for comparison once the clock edge has been taken.
module tb_ls299;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cp = 1'b0;
  logic       mr_n = 1'b1;
  logic       s0 = 1'b0;
  logic       s1 = 1'b0;
  logic       oe1_n = 1'b1;
  logic       oe2_n = 1'b1;
  logic       ds0 = 1'b0;
  logic       ds7 = 1'b0;
  logic [7:0] io_in = '0;
  logic [7:0] io_out;
  logic       io_oe;
  logic       q0s;
  logic       q7s;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e;

  ls299 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cp      (cp),
    .mr_n    (mr_n),
    .s0      (s0),
    .s1      (s1),
    .oe1_n   (oe1_n),
    .oe2_n   (oe2_n),
    .ds0     (ds0),
    .ds7     (ds7),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .q0s     (q0s),
    .q7s     (q7s)
  );

  always #5 clk = ~clk;

  // Advance one clk edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Low sample of cp then a high sample, with mode and data presented on the rising sample.
  task automatic pulse(input logic [1:0] mode, input logic d0, input logic d7, input logic [7:0] din);
    cp = 1'b0;
    tick();
    {s1, s0} = mode;
    ds0 = d0;
    ds7 = d7;
    io_in = din;
    cp = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cp = 1'b1;
    {s1, s0} = 2'b11;
    io_in = 8'hA5;
    tick();
    tick();
    n_cmp++;
    if (io_out !== 8'h00 || q0s !== 1'b0 || q7s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: io_out=%h q0s=%b q7s=%b expected 00 0 0", io_out, q0s, q7s);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e) begin
        n_err++;
        $display("FAIL reset_cp_high[%0d]: io_out=%h expected %h", i, io_out, e);
      end
    end
  endtask

  task automatic test_load_shift_right();
    logic [7:0] tbl[4];
    tbl = '{8'h81, 8'h03, 8'h07, 8'h0F};
    exp_q.push_back(tbl[0]);
    pulse(2'b11, 1'b0, 1'b0, 8'h81);
    e = exp_q.pop_front();
    n_cmp++;
    if (io_out !== e) begin
      n_err++;
      $display("FAIL load_81: io_out=%h expected %h", io_out, e);
    end
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(tbl[i]);
      pulse(2'b01, 1'b1, 1'b0, 8'h00);
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e) begin
        n_err++;
        $display("FAIL shift_right[%0d]: io_out=%h expected %h", i, io_out, e);
      end
      if (i == 1) begin
        n_cmp++;
        if (q7s !== 1'b0) begin
          n_err++;
          $display("FAIL q7s_after_shr: q7s=%b expected 0", q7s);
        end
      end
    end
  endtask

  task automatic test_shift_left();
    exp_q.push_back(8'h01);
    pulse(2'b11, 1'b0, 1'b0, 8'h01);
    e = exp_q.pop_front();
    n_cmp++;
    if (io_out !== e || q0s !== 1'b1) begin
      n_err++;
      $display("FAIL load_01: io_out=%h q0s=%b expected %h 1", io_out, q0s, e);
    end
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 2; i++) begin
      pulse(2'b10, 1'b0, 1'b1, 8'h00);
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e || q0s !== 1'b0 || q7s !== 1'b1) begin
        n_err++;
        $display("FAIL shift_left[%0d]: io_out=%h q0s=%b q7s=%b expected %h 0 1", i, io_out, q0s, q7s, e);
      end
    end
  endtask

  task automatic test_output_enable();
    exp_q.push_back(8'h5A);
    pulse(2'b11, 1'b0, 1'b0, 8'h5A);
    {s1, s0} = 2'b00;
    oe1_n = 1'b0;
    oe2_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (io_oe !== 1'b1 || io_out !== e) begin
      n_err++;
      $display("FAIL oe_enabled: io_oe=%b io_out=%h expected 1 %h", io_oe, io_out, e);
    end
    oe2_n = 1'b1;
    #1;
    n_cmp++;
    if (io_oe !== 1'b0) begin
      n_err++;
      $display("FAIL oe2_high: io_oe=%b expected 0", io_oe);
    end
    oe2_n = 1'b0;
    {s1, s0} = 2'b11;
    #1;
    n_cmp++;
    if (io_oe !== 1'b0) begin
      n_err++;
      $display("FAIL oe_mode11: io_oe=%b expected 0", io_oe);
    end
    {s1, s0} = 2'b00;
    oe1_n = 1'b1;
    oe2_n = 1'b1;
  endtask

  task automatic test_clear_priority();
    exp_q.push_back(8'hFF);
    pulse(2'b11, 1'b0, 1'b0, 8'hFF);
    e = exp_q.pop_front();
    n_cmp++;
    if (io_out !== e) begin
      n_err++;
      $display("FAIL load_ff: io_out=%h expected %h", io_out, e);
    end
    cp = 1'b0;
    tick();
    mr_n = 1'b0;
    {s1, s0} = 2'b11;
    io_in = 8'h33;
    cp = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (io_out !== e) begin
      n_err++;
      $display("FAIL clear_wins: io_out=%h expected %h", io_out, e);
    end
    mr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e) begin
        n_err++;
        $display("FAIL post_clear_cp_high[%0d]: io_out=%h expected %h", i, io_out, e);
      end
    end
  endtask

  task automatic test_hold_and_edge_count();
    exp_q.push_back(8'h3C);
    pulse(2'b11, 1'b0, 1'b0, 8'h3C);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h3C);
      pulse(2'b00, 1'b1, 1'b1, 8'hFF);
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e) begin
        n_err++;
        $display("FAIL hold[%0d]: io_out=%h expected %h", i, io_out, e);
      end
    end
    cp = 1'b0;
    tick();
    {s1, s0} = 2'b01;
    ds0 = 1'b0;
    cp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'h78);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (io_out !== e) begin
        n_err++;
        $display("FAIL single_shift[%0d]: io_out=%h expected %h", i, io_out, e);
      end
    end
  endtask

  task automatic test_async_reset_mid_shift();
    exp_q.push_back(8'hF0);
    pulse(2'b11, 1'b0, 1'b0, 8'hF0);
    void'(exp_q.pop_front());
    cp = 1'b0;
    tick();
    {s1, s0} = 2'b01;
    ds0 = 1'b1;
    cp = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: io_out=%h expected 00", io_out);
    end
    tick();
    reset_n = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (io_out !== e) begin
      n_err++;
      $display("FAIL after_reset_no_edge: io_out=%h expected %h", io_out, e);
    end
  endtask

  initial begin
    test_reset();
    test_load_shift_right();
    test_shift_left();
    test_output_enable();
    test_clear_priority();
    test_hold_and_edge_count();
    test_async_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
